// File: rtl/inta_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : inta_sequencer
//  Brief    : Turns asynchronous INTA_n pulses into the ordered imp1 / imp2
//             strobes and bus enables for the 8086-style two-pulse acknowledge.
//  Revision : 1.0  initial release
// ============================================================================
module inta_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LOW     = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic INTA_n,
    input  logic endOfinit,
    input  logic INT,
    input  logic SNGL,
    input  logic en,
    input  logic slaveIr,
    output logic imp1,
    output logic endOfimp1,
    output logic imp2,
    output logic endOfimp2,
    output logic dataOutEn,
    output logic casOutEn,
    output logic spurious,
    output logic ackTimeout,
    output logic busy
);

    localparam int c_LOW_W = $clog2(MIN_LOW + 1);
    localparam int c_GAP_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK1 = 2'd1,
        S_GAP  = 2'd2,
        S_ACK2 = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_valid;
    logic                   r_armed;
    logic [c_LOW_W-1:0]     r_low_cnt;
    logic [c_GAP_W-1:0]     r_gap_cnt;
    state_t                 r_state;
    state_t                 w_next;
    logic                   w_inta_s;
    logic                   w_live;
    logic                   w_qual;
    logic                   w_timeout;

    assign w_inta_s = r_sync[SYNC_STAGES-1];
    assign w_live   = r_valid[SYNC_STAGES-1];

    // r_valid marks when the last sync stage holds a real post-reset sample,
    // so a level held low across reset cannot qualify off the preset ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '1;
            r_valid <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], INTA_n};
            r_valid <= {r_valid[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed   <= 1'b0;
            r_low_cnt <= '0;
        end else begin
            if (w_live && w_inta_s) begin
                r_armed <= 1'b1;
            end
            if (w_inta_s || !r_armed) begin
                r_low_cnt <= '0;
            end else if (r_low_cnt != c_LOW_W'(MIN_LOW)) begin
                r_low_cnt <= r_low_cnt + 1'b1;
            end
        end
    end

    assign w_qual    = r_armed && !w_inta_s && (r_low_cnt == c_LOW_W'(MIN_LOW - 1));
    assign w_timeout = (TIMEOUT != 0) && (r_gap_cnt == c_GAP_W'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        if (!endOfinit) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_qual) w_next = S_ACK1;
                S_ACK1: if (w_inta_s) w_next = S_GAP;
                S_GAP: begin
                    if (w_qual) begin
                        w_next = S_ACK2;
                    end else if (w_timeout) begin
                        w_next = S_IDLE;
                    end
                end
                S_ACK2: if (w_inta_s) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Every output is a function of the state being entered, so all of them
    // change on the same edge as the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gap_cnt  <= '0;
            imp1       <= 1'b0;
            endOfimp1  <= 1'b0;
            imp2       <= 1'b0;
            endOfimp2  <= 1'b0;
            dataOutEn  <= 1'b0;
            casOutEn   <= 1'b0;
            spurious   <= 1'b0;
            ackTimeout <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_next;
            imp1       <= (w_next == S_ACK1);
            imp2       <= (w_next == S_ACK2);
            endOfimp1  <= (r_state == S_ACK1) && (w_next == S_GAP);
            endOfimp2  <= endOfinit && (r_state == S_ACK2) && (w_next == S_IDLE);
            ackTimeout <= endOfinit && (r_state == S_GAP) && (w_next == S_IDLE);
            busy       <= (w_next != S_IDLE);
            casOutEn   <= !SNGL && en && (w_next != S_IDLE);
            dataOutEn  <= (w_next == S_ACK2) && (SNGL || !en || !slaveIr);

            if (w_next == S_IDLE) begin
                spurious <= 1'b0;
            end else if (r_state == S_IDLE) begin
                spurious <= ~INT;
            end

            if (r_state != S_GAP) begin
                r_gap_cnt <= '0;
            end else if (r_gap_cnt != '1) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inta_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inta_sequencer
//  Brief    : Directed and random INTA_n sequences against a run-length model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inta_sequencer;

    localparam int SYNC    = 2;
    localparam int MINLOW  = 2;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst_n, INTA_n, endOfinit, INT, SNGL, en, slaveIr;
    logic imp1, endOfimp1, imp2, endOfimp2, dataOutEn, casOutEn;
    logic spurious, ackTimeout, busy;

    int checks = 0;
    int errors = 0;

    // Reference: history of raw INTA_n samples since reset, plus how far
    // through the two-pulse acknowledge the cycle has progressed.
    bit hist[$];
    int progress;   // 0 none, 1 in first pulse, 2 between pulses, 3 in second
    int gap_elapsed;
    logic e_imp1, e_eo1, e_imp2, e_eo2, e_data, e_cas, e_sp, e_to, e_busy;

    inta_sequencer #(
        .SYNC_STAGES(SYNC),
        .MIN_LOW    (MINLOW),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .INTA_n    (INTA_n),
        .endOfinit (endOfinit),
        .INT       (INT),
        .SNGL      (SNGL),
        .en        (en),
        .slaveIr   (slaveIr),
        .imp1      (imp1),
        .endOfimp1 (endOfimp1),
        .imp2      (imp2),
        .endOfimp2 (endOfimp2),
        .dataOutEn (dataOutEn),
        .casOutEn  (casOutEn),
        .spurious  (spurious),
        .ackTimeout(ackTimeout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        progress    = 0;
        gap_elapsed = 0;
        {e_imp1, e_eo1, e_imp2, e_eo2, e_data, e_cas, e_sp, e_to, e_busy} = '0;
    endtask

    // A pulse qualifies on the edge where the synchronised low run, which must
    // follow a genuine post-reset high sample, is exactly MINLOW long.
    task automatic model_step();
        int  idx;
        int  n;
        bit  s_high;
        bit  q;
        hist.push_back(INTA_n);
        idx    = hist.size() - 1 - SYNC;
        s_high = (idx >= 0) ? hist[idx] : 1'b1;
        q      = 1'b0;
        if (idx >= 0 && hist[idx] == 1'b0) begin
            n = 0;
            while (idx - n >= 0 && hist[idx - n] == 1'b0 && n <= MINLOW) n++;
            q = (n == MINLOW) && (idx - n >= 0);
        end
        e_eo1 = 1'b0;
        e_eo2 = 1'b0;
        e_to  = 1'b0;
        if (!endOfinit) begin
            progress = 0;
        end else begin
            case (progress)
                0: if (q) begin progress = 1; e_sp = ~INT; end
                1: if (s_high) begin progress = 2; e_eo1 = 1'b1; gap_elapsed = 0; end
                2: begin
                    if (q) progress = 3;
                    else if (gap_elapsed + 1 == TIMEOUT) begin progress = 0; e_to = 1'b1; end
                    else gap_elapsed++;
                end
                3: if (s_high) begin progress = 0; e_eo2 = 1'b1; end
                default: progress = 0;
            endcase
        end
        if (progress == 0) e_sp = 1'b0;
        e_imp1 = (progress == 1);
        e_imp2 = (progress == 3);
        e_busy = (progress != 0);
        e_cas  = !SNGL && en && (progress != 0);
        e_data = (progress == 3) && (SNGL || !en || !slaveIr);
    endtask

    task automatic check_all();
        chk("imp1", imp1, e_imp1);
        chk("endOfimp1", endOfimp1, e_eo1);
        chk("imp2", imp2, e_imp2);
        chk("endOfimp2", endOfimp2, e_eo2);
        chk("dataOutEn", dataOutEn, e_data);
        chk("casOutEn", casOutEn, e_cas);
        chk("spurious", spurious, e_sp);
        chk("ackTimeout", ackTimeout, e_to);
        chk("busy", busy, e_busy);
        chk("imp_exclusive", imp1 & imp2, 1'b0);
        chk("end_vs_imp", (endOfimp1 | endOfimp2) & (imp1 | imp2), 1'b0);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse(input int lo, input int hi);
        INTA_n = 1'b0;
        run(lo);
        INTA_n = 1'b1;
        run(hi);
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        run(hold);
        rst_n = 1'b1;
    endtask

    initial begin
        int lo;
        int hi;
        int eo1_seen;
        int eo2_seen;
        rst_n = 1'b0; INTA_n = 1'b1; endOfinit = 1'b1; INT = 1'b1;
        SNGL = 1'b1; en = 1'b1; slaveIr = 1'b0;
        model_reset();
        run(3);
        rst_n = 1'b1;
        run(4);

        // Single-mode pair, counting end strobes as a directed cross-check
        eo1_seen = 0; eo2_seen = 0;
        INTA_n = 1'b0;
        repeat (6) begin cyc(); eo1_seen += endOfimp1; eo2_seen += endOfimp2; end
        INTA_n = 1'b1;
        repeat (4) begin cyc(); eo1_seen += endOfimp1; eo2_seen += endOfimp2; end
        INTA_n = 1'b0;
        repeat (6) begin cyc(); eo1_seen += endOfimp1; eo2_seen += endOfimp2; end
        INTA_n = 1'b1;
        repeat (8) begin cyc(); eo1_seen += endOfimp1; eo2_seen += endOfimp2; end
        chk("single_eo1_once", eo1_seen == 1, 1'b1);
        chk("single_eo2_once", eo2_seen == 1, 1'b1);

        // Glitch shorter than MIN_LOW
        pulse(1, 8);

        // First pulse only: abandoned after the gap timeout
        eo2_seen = 0;
        INTA_n = 1'b0; run(5);
        INTA_n = 1'b1;
        repeat (80) begin cyc(); eo2_seen += endOfimp2; end
        chk("timeout_no_eo2", eo2_seen == 0, 1'b1);

        // Cascade master with slave attached
        SNGL = 1'b0; en = 1'b1; slaveIr = 1'b1;
        pulse(6, 4); pulse(6, 8);
        // Cascade master, own IR
        slaveIr = 1'b0;
        pulse(5, 3); pulse(5, 8);
        // Slave
        en = 1'b0;
        pulse(4, 5); pulse(4, 8);

        // Spurious acknowledge
        SNGL = 1'b1; en = 1'b1; INT = 1'b0;
        pulse(6, 4); pulse(6, 8);
        INT = 1'b1;

        // Reset during the gap, then a normal pair
        pulse(6, 3);
        do_reset(2);
        run(4);
        pulse(6, 4); pulse(6, 8);

        // Reset released while INTA_n held low must not start a cycle
        INTA_n = 1'b0; run(2);
        do_reset(2);
        run(10);
        INTA_n = 1'b1; run(5);
        pulse(6, 4); pulse(6, 8);

        // endOfinit drops mid-cycle
        pulse(6, 3);
        endOfinit = 1'b0; run(3);
        endOfinit = 1'b1; run(4);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                INT = 1'($urandom); SNGL = 1'($urandom);
                en = 1'($urandom); slaveIr = 1'($urandom);
            end
            lo = $urandom_range(1, 8);
            hi = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 75) : $urandom_range(1, 12);
            if ($urandom_range(0, 19) == 0) begin
                endOfinit = 1'b0; run($urandom_range(1, 3)); endOfinit = 1'b1;
            end
            pulse(lo, hi);
        end
        run(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
